// File: rtl/key_logic_gate_pkg.sv
// key_logic_gate_pkg: mode codes and mode sequencing shared by the key_logic_gate slice
package key_logic_gate_pkg;
    typedef logic [2:0] mode_t;
    localparam mode_t MODE_AND   = 3'd0;
    localparam mode_t MODE_NAND  = 3'd1;
    localparam mode_t MODE_OR    = 3'd2;
    localparam mode_t MODE_NOR   = 3'd3;
    localparam mode_t MODE_XOR   = 3'd4;
    localparam mode_t MODE_XNOR  = 3'd5;
    localparam mode_t MODE_RESET = MODE_NAND;
    localparam mode_t MODE_LAST  = MODE_XNOR;
    function automatic mode_t next_mode(input mode_t m);
        return (m == MODE_LAST) ? MODE_AND : m + 3'd1;
    endfunction
endpackage

// File: rtl/key_logic_gate_if.sv
// key_logic_gate_if: key pins in, LED pins out
interface key_logic_gate_if #(
    parameter int N_KEYS = 2
);
    logic [N_KEYS-1:0] key_n;
    logic              mode_key_n;
    logic              led_n;
    logic [2:0]        mode_led_n;
    modport master (output key_n, output mode_key_n, input led_n, input mode_led_n);
    modport slave  (input key_n, input mode_key_n, output led_n, output mode_led_n);
endinterface

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchroniser plus hold-time debouncer with a press pulse on 1->0
module key_debounce #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_n,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEB_CYCLES);
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          done;
    assign done  = (cnt == CW'(DEB_CYCLES - 1));
    assign press = level & ~sync[1] & done;
    // Synchronise, then accept a new level only after it has differed for DEB_CYCLES cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= 2'b11;
            level <= 1'b1;
            cnt   <= '0;
        end else begin
            sync <= {sync[0], raw_n};
            if (sync[1] == level) cnt <= '0;
            else if (done) begin
                level <= sync[1];
                cnt   <= '0;
            end else cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/key_logic_gate.sv
// key_logic_gate: debounced N-key logic gate driving one active-low LED
// Build option KEY_LOGIC_GATE_MODE_SEL_EN adds the mode key, mode register and mode cycling.
module key_logic_gate
    import key_logic_gate_pkg::*;
#(
    parameter int N_KEYS     = 2,
    parameter int DEB_CYCLES = 1000000
) (
    input logic             clk,
    input logic             rst,
    key_logic_gate_if.slave bus
);
    logic [N_KEYS-1:0] level;
    logic [N_KEYS-1:0] unused_press;
    mode_t             mode;
    logic              gate_res;
    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk(clk), .rst(rst), .raw_n(bus.key_n[k]), .level(level[k]), .press(unused_press[k])
        );
    end
`ifdef KEY_LOGIC_GATE_MODE_SEL_EN
    logic mode_press;
    logic unused_mode_level;
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode_deb (
        .clk(clk), .rst(rst), .raw_n(bus.mode_key_n), .level(unused_mode_level), .press(mode_press)
    );
    // Advance the mode once per debounced mode-key press, wrapping after XNOR
    always_ff @(posedge clk) begin
        mode <= rst ? MODE_RESET : mode_press ? next_mode(mode) : mode;
    end
`else
    logic unused_mode_key;
    assign unused_mode_key = bus.mode_key_n;
    assign mode            = MODE_RESET;
`endif
    // Gate across all debounced levels; unreachable codes 6 and 7 behave as NAND
    always_comb begin
        gate_res = (mode == MODE_AND)  ? &level  :
                   (mode == MODE_OR)   ? |level  :
                   (mode == MODE_NOR)  ? ~|level :
                   (mode == MODE_XOR)  ? ^level  :
                   (mode == MODE_XNOR) ? ~^level : ~&level;
    end
    // Register the gate result straight onto the LED pin
    always_ff @(posedge clk) begin
        bus.led_n <= rst ? 1'b0 : gate_res;
    end
    assign bus.mode_led_n = ~mode;
endmodule

// File: tb/tb_key_logic_gate.sv
// tb_key_logic_gate: directed and randomized checks of key_logic_gate against a behavioural model
module tb_key_logic_gate;
    localparam int DEB = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails  = 0;
    key_logic_gate_if #(.N_KEYS(2)) ia ();
    key_logic_gate_if #(.N_KEYS(3)) ib ();
    key_logic_gate #(.N_KEYS(2), .DEB_CYCLES(DEB)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
    key_logic_gate #(.N_KEYS(3), .DEB_CYCLES(DEB)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
    always #5 clk = ~clk;
`ifdef KEY_LOGIC_GATE_MODE_SEL_EN
    logic [2:0] exp_seq [6] = '{3'b101, 3'b100, 3'b011, 3'b010, 3'b111, 3'b110};
    logic       exp_or  = 1'b1;
    logic       exp_x1  = 1'b0;
`else
    logic [2:0] exp_seq [6] = '{3'b110, 3'b110, 3'b110, 3'b110, 3'b110, 3'b110};
    logic       exp_or  = 1'b0;
    logic       exp_x1  = 1'b1;
`endif
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // Behavioural model: sync delay of 2, a level flips after DEB consecutive differing cycles,
    // mode counts debounced presses modulo 6, LED is the previous cycle's gate result.
    int       nk [2] = '{2, 3};
    bit [7:0] s0 [2], s1 [2], stab [2];
    int       run [2][8];
    bit       ms0 [2], ms1 [2], mstab [2];
    int       mrun [2];
    int       mode_m [2];
    bit       led_m [2];
    bit       valid = 0;
    bit [7:0] raw_m;
    bit       mraw_m, mprev;
    function automatic bit gate_f(input int m, input bit [7:0] lv, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) c += int'(lv[i]);
        case (m)
            0: return c == n;
            2: return c > 0;
            3: return c == 0;
            4: return (c % 2) == 1;
            5: return (c % 2) == 0;
            default: return c != n;
        endcase
    endfunction
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            raw_m  = (d == 0) ? 8'(ia.key_n) : 8'(ib.key_n);
            mraw_m = (d == 0) ? ia.mode_key_n : ib.mode_key_n;
            if (rst) begin
                s0[d] = '1; s1[d] = '1; stab[d] = '1;
                ms0[d] = 1; ms1[d] = 1; mstab[d] = 1; mrun[d] = 0;
                mode_m[d] = 1; led_m[d] = 0;
                for (int i = 0; i < 8; i++) run[d][i] = 0;
                valid = 1;
            end else if (valid) begin
                led_m[d] = gate_f(mode_m[d], stab[d], nk[d]);
                for (int i = 0; i < 8; i++) begin
                    if (s1[d][i] == stab[d][i]) run[d][i] = 0;
                    else begin
                        run[d][i]++;
                        if (run[d][i] == DEB) begin
                            stab[d][i] = s1[d][i];
                            run[d][i] = 0;
                        end
                    end
                end
                mprev = mstab[d];
                if (ms1[d] == mstab[d]) mrun[d] = 0;
                else begin
                    mrun[d]++;
                    if (mrun[d] == DEB) begin
                        mstab[d] = ms1[d];
                        mrun[d] = 0;
                    end
                end
`ifdef KEY_LOGIC_GATE_MODE_SEL_EN
                if (mprev && !mstab[d]) mode_m[d] = (mode_m[d] + 1) % 6;
`endif
                s1[d] = s0[d]; s0[d] = raw_m;
                ms1[d] = ms0[d]; ms0[d] = mraw_m;
            end
        end
    end
    always @(negedge clk) begin
        if (valid) begin
            chk("model_led_a", 32'(ia.led_n), 32'(led_m[0]));
            chk("model_mode_a", 32'(ia.mode_led_n), 32'(3'(mode_m[0]) ^ 3'b111));
            chk("model_led_b", 32'(ib.led_n), 32'(led_m[1]));
            chk("model_mode_b", 32'(ib.mode_led_n), 32'(3'(mode_m[1]) ^ 3'b111));
        end
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        ia.key_n = '1; ia.mode_key_n = 1'b1;
        ib.key_n = '1; ib.mode_key_n = 1'b1;
        step();
        step();
        chk("reset_led_a", 32'(ia.led_n), 32'd0);
        chk("reset_mode_a", 32'(ia.mode_led_n), 32'b110);
        chk("reset_led_b", 32'(ib.led_n), 32'd0);
        rst = 1'b0;
    endtask
    task automatic press_mode_b();
        ib.mode_key_n = 1'b0;
        repeat (6) step();
        ib.mode_key_n = 1'b1;
        repeat (6) step();
    endtask
    int changes, first_edge;
    logic prev;
    initial begin
        ia.key_n = '1; ia.mode_key_n = 1'b1;
        ib.key_n = '1; ib.mode_key_n = 1'b1;
        do_reset();
        ia.key_n = 2'b10;
        for (int e = 1; e <= 9; e++) begin
            step();
            chk($sformatf("held_key_edge%0d", e), 32'(ia.led_n), 32'(e >= 7));
        end
        do_reset();
        ia.key_n = 2'b10;
        repeat (3) step();
        ia.key_n = 2'b11;
        repeat (12) step();
        chk("short_pulse", 32'(ia.led_n), 32'd0);
        do_reset();
        changes = 0; first_edge = 0; prev = ia.led_n;
        for (int c = 0; c <= 40; c++) begin
            ia.key_n = {1'b1, (c < 20) ? 1'((c / 2) % 2) : 1'b0};
            step();
            if (ia.led_n !== prev) begin
                changes++;
                if (changes == 1) first_edge = c + 1;
                prev = ia.led_n;
            end
        end
        chk("bounce_changes", 32'(changes), 32'd1);
        chk("bounce_edge", 32'(first_edge), 32'd27);
        do_reset();
        for (int p = 0; p < 6; p++) begin
            ia.mode_key_n = 1'b0;
            repeat (6) step();
            chk($sformatf("mode_seq%0d", p), 32'(ia.mode_led_n), 32'(exp_seq[p]));
            ia.mode_key_n = 1'b1;
            repeat (6) step();
            if (p == 0) chk("or_released", 32'(ia.led_n), 32'(exp_or));
        end
        do_reset();
        repeat (3) press_mode_b();
        ib.key_n = 3'b110;
        repeat (10) step();
        chk("xor_110", 32'(ib.led_n), 32'(exp_x1));
        ib.key_n = 3'b100;
        repeat (10) step();
        chk("xor_100", 32'(ib.led_n), 32'd1);
        do_reset();
        ia.key_n = 2'b10;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            step();
            chk($sformatf("held_thru_rst_edge%0d", e), 32'(ia.led_n), 32'(e >= 7));
        end
        do_reset();
        ia.key_n = 2'b10;
        repeat (3) step();
        rst = 1'b1;
        ia.key_n = 2'b11;
        step();
        rst = 1'b0;
        repeat (10) step();
        chk("rst_mid_debounce", 32'(ia.led_n), 32'd0);
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) ia.key_n = 2'($urandom);
            if ($urandom_range(0, 5) == 0) ib.key_n = 3'($urandom);
            if ($urandom_range(0, 7) == 0) ia.mode_key_n = ~ia.mode_key_n;
            if ($urandom_range(0, 7) == 0) ib.mode_key_n = ~ib.mode_key_n;
            rst = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0;
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/key_logic_gate.md
# key_logic_gate

Parametrised, registered logic-gate block for the board's push-button/LED demos. Synchronises and debounces N active-low operand keys, applies a run-time-selectable gate function across all of them, and drives one active-low LED. A separate mode key cycles the function, shown on three active-low LEDs. It sits directly between the key pins and the LED pins.

## Interface
- N_KEYS, 2: number of operand keys; legal range 2..8.
- DEB_CYCLES, 1000000: debounce hold time in clk cycles (20 ms at 50 MHz); minimum 2.
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- key_n  input  N_KEYS  raw operand keys, active-low: 0 = pressed, 1 = released.
- mode_key_n  input  1  raw mode-select key, active-low.
- led_n  output  1  gate result, driven directly to the LED pin: 0 = lit.
- mode_led_n  output  3  current mode code, bitwise inverted: LED lit = code bit 1.

## Operation
- Each key (operands and mode key) passes through a 2-flop synchroniser, then a debouncer.
- Each debouncer holds a stable level and a counter.
  - When the synchronised level equals the stable level, the counter clears.
  - When it differs, the counter increments.
  - When the counter equals DEB_CYCLES-1 and the levels still differ, the stable level takes the synchronised value and the counter clears.
- The gate operates on the debounced levels as seen at the pins (1 = released), across all N_KEYS bits.
- Mode codes:
  - AND = 0, NAND = 1, OR = 2, NOR = 3.
  - XOR = 4: odd parity.
  - XNOR = 5: even parity.
- Codes 6 and 7 are unreachable. If they ever occur, the gate treats them as NAND.
- A mode-key press is the stable level falling 1→0. Each press advances the mode by one: AND→NAND→OR→NOR→XOR→XNOR→AND. A key release has no effect.
- led_n is a register loaded every cycle with gate(mode, stable levels).
- Reset values:
  - synchroniser flops and stable levels: all 1;
  - counters: 0;
  - mode: NAND;
  - led_n: 0;
  - mode_led_n: 3'b110.

## Timing
- Raw key edge to synchroniser output: 2 cycles.
- Synchroniser output to stable-level update: DEB_CYCLES cycles.
- Stable-level update to led_n: 1 cycle.
- Raw operand edge, held steady, to led_n change: DEB_CYCLES+3 cycles.
- Raw mode-key press to mode_led_n change: DEB_CYCLES+2 cycles, because mode updates on the same edge as the stable level. led_n reflects the new mode one cycle later.
- A raw pulse or bounce shorter than DEB_CYCLES synchronised cycles produces no change. A bounce restarts the count from 0.
- If an operand change and a mode change land on the same edge, the next led_n uses both new values. There is no intermediate output.
- Keys pressed together debounce independently. Each one's counter runs on its own.
- Reset mid-operation: all partial counts are discarded.
  - An operand key held through reset release is re-debounced and appears after DEB_CYCLES+3 cycles.
  - A mode key held through reset release counts as one press after DEB_CYCLES+2 cycles, so the mode advances to OR.

## Configuration
- KEY_LOGIC_GATE_MODE_SEL_EN
  - Defined: mode register, mode-key synchroniser and debouncer, and mode cycling are built as described above.
  - Undefined: mode is the constant NAND, mode_key_n is ignored, mode_led_n is tied to 3'b110, and no logic is built for the mode key.
  - Operand debouncing and led_n timing are identical in both builds.

## Structure
- Package key_logic_gate_pkg holds:
  - the 3-bit mode code constants (MODE_AND … MODE_XNOR);
  - MODE_RESET = MODE_NAND;
  - MODE_LAST = MODE_XNOR, used for the wrap back to AND.
- Sub-module key_debounce holds one synchroniser, counter and stable level.
  - Parameter: DEB_CYCLES.
  - Outputs: level, plus a press pulse on the 1→0 transition.
  - key_logic_gate instantiates it N_KEYS times, plus once for the mode key when the macro is defined.
- Counter width is $clog2(DEB_CYCLES), computed locally.

## Test plan
All scenarios run with DEB_CYCLES=4 and N_KEYS=2 unless stated otherwise.
- Reset, keys released → led_n=0, mode_led_n=3'b110.
- key_n=2'b10 held from cycle 0 → led_n=0 through cycle 6, and led_n=1 at cycle 7 (NAND with one key pressed).
- key_n bit0 low for 3 cycles, then high → led_n stays 0 throughout.
- key_n bit0 bouncing 0/1 every 2 cycles for 20 cycles, then held low → exactly one led_n transition, 7 cycles after the final edge.
- Mode key held 6 cycles, then released; repeat 6 times → mode_led_n sequence 101, 100, 011, 010, 111, 110.
  - The first press gives OR, so led_n=1 with keys released.
  - Six presses wrap back to NAND.
- N_KEYS=3, mode XOR:
  - key_n=3'b110 → led_n=0 (levels 110 have even parity);
  - then key_n=3'b100 → led_n=1.
  - Separately, assert rst mid-debounce on key0 → the count is discarded and led_n keeps its reset value.
